// File: rtl/fpu_register_file.sv
// fpu_register_file: single-precision FP register file with frm/fflags CSRs and a single-op writeback scoreboard
// Reads bypass same-cycle writes; an FPU writeback always beats a concurrent FLW.
module fpu_register_file #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] f_rs1,
    input  logic [ADDR_W-1:0] f_rs2,
    input  logic [ADDR_W-1:0] f_rd,
    input  logic              f_issue,
    input  logic              f_LW,
    input  logic              f_SW,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] FPU_out,
    input  logic              f_ready,
    input  logic [4:0]        flags,
    input  logic [2:0]        inst_rm,
    input  logic [2:0]        f_frm_in,
    input  logic              frm_wen,
    input  logic [4:0]        fflags_wdata,
    input  logic              fflags_wen,
    output logic [DATA_W-1:0] f_rs1_data,
    output logic [DATA_W-1:0] f_rs2_data,
    output logic [2:0]        frm,
    output logic              rm_invalid,
    output logic [2:0]        f_frm_out,
    output logic [4:0]        f_flags,
    output logic              stall
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        frm_reg;
    logic [4:0]        fflags_reg;
    logic              busy;
    logic [ADDR_W-1:0] wb_rd;
    logic              hz;
    logic              ld_we;

    always_comb begin
        // an issue always waits for the outstanding op; a store only cares about its data register
        hz = f_issue | (f_LW & (f_rs1 == wb_rd | f_rs2 == wb_rd | f_rd == wb_rd)) | (f_SW & f_rs2 == wb_rd);
        stall = (busy & ~f_ready & hz) | (f_LW & f_ready);
        ld_we = f_LW & ~stall;
        f_rs1_data = (f_ready && f_rs1 == wb_rd) ? FPU_out :
                     (ld_we && f_rs1 == f_rd) ? dmem_rdata : regs[f_rs1];
        f_rs2_data = (f_ready && f_rs2 == wb_rd) ? FPU_out :
                     (ld_we && f_rs2 == f_rd) ? dmem_rdata : regs[f_rs2];
        frm = (inst_rm == 3'b111) ? frm_reg : inst_rm;
        rm_invalid = frm >= 3'b101;
        f_frm_out = frm_reg;
        f_flags = fflags_reg;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            frm_reg <= '0;
            fflags_reg <= '0;
            busy <= 1'b0;
            wb_rd <= '0;
        end else begin
            if (f_ready) regs[wb_rd] <= FPU_out;
            if (ld_we) regs[f_rd] <= dmem_rdata;
            if (frm_wen) frm_reg <= f_frm_in;
            fflags_reg <= (fflags_wen ? fflags_wdata : fflags_reg) | (f_ready ? flags : 5'd0);
            if (f_issue & ~stall) begin
                busy <= 1'b1;
                wb_rd <= f_rd;
            end else if (f_ready) begin
                busy <= 1'b0;
            end
        end
    end
endmodule
